tetris_game_ctrl: RTL and testbench
===================================

Name: tetris_game_ctrl

Overview:
Single-clock game sequencer for the 8-row x 4-column tetris board (32-bit vector, row r = bits [4r+3:4r], row 0 top, row 7 bottom, column c = bit 4r+c).
- Owns the settled-cell stack and the active piece mask.
- Spawns pieces, applies left/right moves and gravity ticks, locks pieces, clears full rows iteratively, and detects game over.
- Output board feeds the display path.

Parameters:
- ROWS, 8, board rows (fixed at 8 for the 32-bit board; no other value supported)
- LINE_CNT_W, 8, width of the saturating cleared-lines counter

Ports:
- clka  input  1  clock, rising-edge
- restart  input  1  asynchronous, active-low reset
- start  input  1  level; begins a new game from IDLE or GAMEOVER
- tick  input  1  1-cycle gravity pulse
- move_left  input  1  1-cycle move request toward column 0
- move_right  input  1  1-cycle move request toward column 3
- next_piece  input  2  piece type consumed at spawn: 00 single, 01 horizontal pair, 10 square, 11 L
- piece_req  output  1  1-cycle pulse when next_piece is consumed
- board_out  output  32  stack OR active mask, registered
- busy  output  1  high in SPAWN, LOCK, CLEAR
- game_over  output  1  high in GAMEOVER
- lines_cleared  output  LINE_CNT_W  cleared-row count, saturating

Behaviour:
- Reset (restart=0, async): state=IDLE; stack, mask, board_out, lines_cleared = 0; piece_req, busy, game_over = 0.
- Spawn masks:
  - 00 = bit1 (0x00000002)
  - 01 = bits 1,2 (0x00000006)
  - 10 = bits 1,2,5,6 (0x00000066)
  - 11 = bits 1,5,6 (0x00000062)
- IDLE: start=1 -> SPAWN; stack and lines_cleared cleared on this transition.
- SPAWN (1 cycle):
  - Sample next_piece and pulse piece_req.
  - If (spawn mask & stack) != 0 -> GAMEOVER, with the colliding mask still shown in board_out.
  - Otherwise mask = spawn mask -> FALL.
- FALL: one action per cycle, priority tick > move_left > move_right.
  - move_left and move_right together (without tick): no move.
  - tick: candidate = mask << 4. If mask has any bit in row 7, or candidate & stack != 0 -> LOCK. Otherwise mask = candidate.
  - move_left: legal only if no mask bit in column 0 and ((mask >> 1) & stack) == 0; otherwise ignored, no error.
  - move_right: legal only if no mask bit in column 3 and ((mask << 1) & stack) == 0; otherwise ignored.
- LOCK (1 cycle): stack |= mask; mask = 0; scan row r = 7 -> CLEAR.
- CLEAR (1 row per cycle):
  - If stack row r == 4'hF: rows r..1 take rows r-1..0, row 0 = 0, lines_cleared++ (saturates at 2^LINE_CNT_W-1), r unchanged (rechecked next cycle).
  - Otherwise, if r == 0 -> SPAWN; else r--.
  - Worst-case duration: 8 + rows cleared cycles.
- GAMEOVER: hold board_out, game_over=1; start=1 -> SPAWN, clearing stack and lines_cleared on the transition.
- start, tick and move inputs are ignored outside the states above (no queuing).
- board_out updates on the cycle following each state or register change (1-cycle registered latency).
- restart asserted mid-CLEAR or mid-FALL: immediate async return to reset values; no partial state survives.

Test Plan:
1. Spawn: reset, start=1, next_piece=10 -> piece_req pulses once; board_out=0x00000066 in FALL; busy=0.
2. Fall and lock of single: next_piece=00, 7 ticks -> board_out=0x20000000. 8th tick -> LOCK, CLEAR, respawn; with next_piece=00 board_out=0x20000002; lines_cleared=0.
3. Edges: next_piece=01. move_right -> 0x0000000C; move_right again -> unchanged 0x0000000C. Three move_left -> 0x00000003. move_left+move_right together -> no change.
4. Single-row clear: four singles placed in cols 0,1,2,3 (left x1, none, right x1, right x2), each dropped to row 7 -> after 4th lock row 7 clears; stack=0, lines_cleared=1, board_out shows only the new spawn.
5. Double clear: square moved left to cols 0-1 and dropped, square moved right to cols 2-3 and dropped -> rows 6,7 clear in consecutive CLEAR cycles; lines_cleared=2, stack=0.
6. Game over and reset: 4 squares dropped with no moves fill cols 1-2 of rows 0..7. 5th spawn collides -> game_over=1, ticks/moves ignored. start -> new game, lines_cleared=0. restart=0 during CLEAR -> all outputs 0 immediately.

Source files
------------

// File: rtl/tetris_game_ctrl.sv
// Game sequencer for the 8x4 tetris board: owns the settled stack and the active piece,
// runs spawn / fall / lock / row-clear, and presents the registered composite board.
module tetris_game_ctrl #(
    parameter int ROWS       = 8,
    parameter int LINE_CNT_W = 8
) (
    input  logic                  clka,
    input  logic                  restart,
    input  logic                  start,
    input  logic                  tick,
    input  logic                  move_left,
    input  logic                  move_right,
    input  logic [1:0]            next_piece,
    output logic                  piece_req,
    output logic [4*ROWS-1:0]     board_out,
    output logic                  busy,
    output logic                  game_over,
    output logic [LINE_CNT_W-1:0] lines_cleared,
    output logic [2:0]            state_dbg
);

    localparam int BW = 4 * ROWS;
    localparam int RW = $clog2(ROWS);
    localparam logic [BW-1:0] COL0 = {ROWS{4'b0001}};
    localparam logic [BW-1:0] COL3 = {ROWS{4'b1000}};

    // state_dbg carries this encoding directly.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPAWN    = 3'd1,
        S_FALL     = 3'd2,
        S_LOCK     = 3'd3,
        S_CLEAR    = 3'd4,
        S_GAMEOVER = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         stack_q, stack_d;
    logic [BW-1:0]         mask_q, mask_d;
    logic [BW-1:0]         board_q;
    logic [RW-1:0]         row_q, row_d;
    logic [LINE_CNT_W-1:0] lines_q, lines_d;

    logic [BW-1:0] spawn_mask;
    logic [BW-1:0] collapsed;
    logic [3:0]    scan_row;

    always_comb begin
        spawn_mask = '0;
        case (next_piece)
            2'b00:   spawn_mask = BW'(32'h0000_0002);
            2'b01:   spawn_mask = BW'(32'h0000_0006);
            2'b10:   spawn_mask = BW'(32'h0000_0066);
            default: spawn_mask = BW'(32'h0000_0062);
        endcase
    end

    // Rows above and including row_q drop by one; rows below it are untouched.
    always_comb begin
        collapsed = stack_q;
        for (int i = 0; i < ROWS; i++) begin
            if (RW'(i) <= row_q) begin
                if (i == 0) collapsed[3:0] = 4'h0;
                else        collapsed[4*i +: 4] = stack_q[4*(i-1) +: 4];
            end
        end
    end

    assign scan_row = stack_q[{row_q, 2'b00} +: 4];

    // Handshake: piece_req is high for exactly the one SPAWN cycle in which next_piece
    // is sampled; the producer must hold next_piece valid through that cycle and may
    // advance to the following piece once it has seen the pulse.
    always_comb begin
        state_d   = state_q;
        stack_d   = stack_q;
        mask_d    = mask_q;
        row_d     = row_q;
        lines_d   = lines_q;
        piece_req = 1'b0;
        case (state_q)
            S_IDLE, S_GAMEOVER: begin
                if (start) begin
                    state_d = S_SPAWN;
                    stack_d = '0;
                    mask_d  = '0;
                    lines_d = '0;
                end
            end
            S_SPAWN: begin
                piece_req = 1'b1;
                mask_d    = spawn_mask;
                state_d   = ((spawn_mask & stack_q) != '0) ? S_GAMEOVER : S_FALL;
            end
            S_FALL: begin
                if (tick) begin
                    if ((|mask_q[BW-1 -: 4]) || (((mask_q << 4) & stack_q) != '0))
                        state_d = S_LOCK;
                    else
                        mask_d = mask_q << 4;
                end else if (move_left && !move_right) begin
                    if (((mask_q & COL0) == '0) && (((mask_q >> 1) & stack_q) == '0))
                        mask_d = mask_q >> 1;
                end else if (move_right && !move_left) begin
                    if (((mask_q & COL3) == '0) && (((mask_q << 1) & stack_q) == '0))
                        mask_d = mask_q << 1;
                end
            end
            S_LOCK: begin
                stack_d = stack_q | mask_q;
                mask_d  = '0;
                row_d   = RW'(ROWS - 1);
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (scan_row == 4'hF) begin
                    // Row index stays put so the row that fell into place is rechecked.
                    stack_d = collapsed;
                    if (lines_q != '1) lines_d = lines_q + 1'b1;
                end else if (row_q == '0) begin
                    state_d = S_SPAWN;
                end else begin
                    row_d = row_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            state_q <= S_IDLE;
            stack_q <= '0;
            mask_q  <= '0;
            row_q   <= '0;
            lines_q <= '0;
            board_q <= '0;
        end else begin
            state_q <= state_d;
            stack_q <= stack_d;
            mask_q  <= mask_d;
            row_q   <= row_d;
            lines_q <= lines_d;
            board_q <= stack_q | mask_q;
        end
    end

    assign board_out     = board_q;
    assign lines_cleared = lines_q;
    assign busy          = (state_q == S_SPAWN) || (state_q == S_LOCK) || (state_q == S_CLEAR);
    assign game_over     = (state_q == S_GAMEOVER);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed bench for tetris_game_ctrl: expected boards are queued as each action is
// driven and checked once the registered board_out catches up.
module tb_tetris_game_ctrl;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SPAWN    = 3'd1;
    localparam logic [2:0] S_FALL     = 3'd2;
    localparam logic [2:0] S_LOCK     = 3'd3;
    localparam logic [2:0] S_CLEAR    = 3'd4;
    localparam logic [2:0] S_GAMEOVER = 3'd5;

    logic        clka;
    logic        restart;
    logic        start;
    logic        tick;
    logic        move_left;
    logic        move_right;
    logic [1:0]  next_piece;
    logic        piece_req;
    logic [31:0] board_out;
    logic        busy;
    logic        game_over;
    logic [7:0]  lines_cleared;
    logic [2:0]  state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;
    int req_cnt = 0;
    int req_base;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    tetris_game_ctrl #(.ROWS(8), .LINE_CNT_W(8)) dut (
        .clka          (clka),
        .restart       (restart),
        .start         (start),
        .tick          (tick),
        .move_left     (move_left),
        .move_right    (move_right),
        .next_piece    (next_piece),
        .piece_req     (piece_req),
        .board_out     (board_out),
        .busy          (busy),
        .game_over     (game_over),
        .lines_cleared (lines_cleared),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clka = 1'b0;
    always #5 clka = ~clka;

    always @(negedge clka) if (piece_req === 1'b1) req_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic sb_check_board();
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, board_out, e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state_dbg !== s && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(state_dbg), 32'(s));
    endtask

    task automatic do_reset();
        @(posedge clka);
        #3 restart = 1'b0;
        @(posedge clka);
        #3 restart = 1'b1;
        cycle();
    endtask

    // Drive one FALL-state action, then compare the board once it has been registered.
    task automatic act(input logic t, input logic l, input logic r,
                       input logic [31:0] e, input string tag);
        tick = t; move_left = l; move_right = r;
        cycle();
        tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
        sb_push(e, tag);
        cycle();
        sb_check_board();
    endtask

    task automatic spawn_check(input logic [1:0] np, input logic [31:0] e, input string tag);
        next_piece = np;
        wait_state(S_FALL, 40, {tag, "_reach_fall"});
        sb_push(e, tag);
        cycle();
        sb_check_board();
    endtask

    task automatic new_game(input logic [1:0] np, input logic [31:0] e, input string tag);
        next_piece = np;
        start = 1'b1;
        cycle();
        start = 1'b0;
        spawn_check(np, e, tag);
    endtask

    task automatic drop(input string tag);
        int n = 0;
        while (state_dbg !== S_LOCK && n < 12) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            n++;
        end
        chk(tag, 32'(state_dbg), 32'(S_LOCK));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        restart = 1'b0; start = 1'b0; tick = 1'b0;
        move_left = 1'b0; move_right = 1'b0; next_piece = 2'b00;
        repeat (3) @(posedge clka);
        #1;
        chk("rst_board", board_out, 32'h0);
        chk("rst_lines", 32'(lines_cleared), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_game_over", 32'(game_over), 32'h0);
        chk("rst_piece_req", 32'(piece_req), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        restart = 1'b1;
        cycle();

        // 1. spawn of a square
        req_base = req_cnt;
        next_piece = 2'b10;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("spawn_busy", 32'(busy), 32'h1);
        chk("spawn_req", 32'(piece_req), 32'h1);
        spawn_check(2'b10, 32'h0000_0066, "spawn_square");
        chk("fall_busy", 32'(busy), 32'h0);
        chk("req_count", 32'(req_cnt - req_base), 32'h1);

        // 2. single falls to the floor, locks, next single spawns
        do_reset();
        new_game(2'b00, 32'h0000_0002, "single_spawn");
        for (int k = 1; k <= 7; k++)
            act(1'b1, 1'b0, 1'b0, 32'h0000_0002 << (4 * k), $sformatf("single_tick%0d", k));
        drop("single_lock");
        chk("lock_busy", 32'(busy), 32'h1);
        spawn_check(2'b00, 32'h2000_0002, "single_respawn");
        chk("single_lines", 32'(lines_cleared), 32'h0);

        // 3. wall edges and simultaneous moves
        do_reset();
        new_game(2'b01, 32'h0000_0006, "pair_spawn");
        act(1'b0, 1'b0, 1'b1, 32'h0000_000C, "pair_right1");
        act(1'b0, 1'b0, 1'b1, 32'h0000_000C, "pair_right_wall");
        act(1'b0, 1'b1, 1'b0, 32'h0000_0006, "pair_left1");
        act(1'b0, 1'b1, 1'b0, 32'h0000_0003, "pair_left2");
        act(1'b0, 1'b1, 1'b0, 32'h0000_0003, "pair_left_wall");
        act(1'b0, 1'b1, 1'b1, 32'h0000_0003, "pair_both");
        act(1'b1, 1'b0, 1'b1, 32'h0000_0030, "pair_tick_priority");

        // 4. four singles complete row 7
        do_reset();
        new_game(2'b00, 32'h0000_0002, "row_spawn1");
        act(1'b0, 1'b1, 1'b0, 32'h0000_0001, "row_p1_left");
        drop("row_p1_lock");
        spawn_check(2'b00, 32'h1000_0002, "row_spawn2");
        drop("row_p2_lock");
        spawn_check(2'b00, 32'h3000_0002, "row_spawn3");
        act(1'b0, 1'b0, 1'b1, 32'h3000_0004, "row_p3_right");
        drop("row_p3_lock");
        spawn_check(2'b00, 32'h7000_0002, "row_spawn4");
        act(1'b0, 1'b0, 1'b1, 32'h7000_0004, "row_p4_right1");
        act(1'b0, 1'b0, 1'b1, 32'h7000_0008, "row_p4_right2");
        drop("row_p4_lock");
        spawn_check(2'b00, 32'h0000_0002, "row_cleared_spawn");
        chk("row_lines", 32'(lines_cleared), 32'h1);

        // 5. two squares complete rows 6 and 7
        do_reset();
        new_game(2'b10, 32'h0000_0066, "dbl_spawn1");
        act(1'b0, 1'b1, 1'b0, 32'h0000_0033, "dbl_sq1_left");
        drop("dbl_sq1_lock");
        spawn_check(2'b10, 32'h3300_0066, "dbl_spawn2");
        act(1'b0, 1'b0, 1'b1, 32'h3300_00CC, "dbl_sq2_right");
        drop("dbl_sq2_lock");
        cycle();
        chk("dbl_clear_state", 32'(state_dbg), 32'(S_CLEAR));
        chk("dbl_lines0", 32'(lines_cleared), 32'h0);
        cycle();
        chk("dbl_lines1", 32'(lines_cleared), 32'h1);
        cycle();
        chk("dbl_lines2", 32'(lines_cleared), 32'h2);
        spawn_check(2'b10, 32'h0000_0066, "dbl_cleared_spawn");
        chk("dbl_lines_final", 32'(lines_cleared), 32'h2);

        // 6. column of squares ends the game
        do_reset();
        new_game(2'b10, 32'h0000_0066, "go_spawn1");
        drop("go_sq1_lock");
        spawn_check(2'b10, 32'h6600_0066, "go_spawn2");
        drop("go_sq2_lock");
        spawn_check(2'b10, 32'h6666_0066, "go_spawn3");
        drop("go_sq3_lock");
        spawn_check(2'b10, 32'h6666_6666, "go_spawn4");
        drop("go_sq4_lock");
        next_piece = 2'b10;
        wait_state(S_GAMEOVER, 40, "go_reach_gameover");
        sb_push(32'h6666_6666, "go_board");
        cycle();
        sb_check_board();
        chk("go_flag", 32'(game_over), 32'h1);
        chk("go_busy", 32'(busy), 32'h0);
        act(1'b1, 1'b1, 1'b0, 32'h6666_6666, "go_ignore_inputs");
        chk("go_hold_state", 32'(state_dbg), 32'(S_GAMEOVER));
        new_game(2'b00, 32'h0000_0002, "go_restart_spawn");
        chk("go_restart_lines", 32'(lines_cleared), 32'h0);
        chk("go_restart_flag", 32'(game_over), 32'h0);

        // async reset in the middle of CLEAR
        drop("rc_lock");
        cycle();
        chk("rc_in_clear", 32'(state_dbg), 32'(S_CLEAR));
        chk("rc_board_before", board_out, 32'h2000_0000);
        #2 restart = 1'b0;
        #1;
        chk("rc_board", board_out, 32'h0);
        chk("rc_lines", 32'(lines_cleared), 32'h0);
        chk("rc_busy", 32'(busy), 32'h0);
        chk("rc_state", 32'(state_dbg), 32'(S_IDLE));
        #4 restart = 1'b1;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
